// File: rtl/sa_autosa_sdp_rdma_pkg.sv
// rtl/sa_autosa_sdp_rdma_pkg.sv - shared field layout and FSM states for the SDP read-DMA unpack path
package sa_autosa_sdp_rdma_pkg;

  localparam int DATA_W       = 64;
  localparam int CMD_PD_W     = 15;
  localparam int CMD_CNT_W    = 13;
  localparam int CMD_EOS_BIT  = 13;
  localparam int CMD_LEND_BIT = 14;
  localparam int DP_PD_W      = 66;
  localparam int DP_LAST_BIT  = 64;
  localparam int DP_LEND_BIT  = 65;
  localparam int STATUS_W     = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/sa_autosa_sdp_rdma_lat_fifo.sv
// rtl/sa_autosa_sdp_rdma_lat_fifo.sv - latency FIFO with registered head-of-queue read data
module sa_autosa_sdp_rdma_lat_fifo
  import sa_autosa_sdp_rdma_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q, head_ptr;
  logic [AW:0]       cnt_q, cnt_d, remain;
  logic              push, pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign pop      = rd_en & !empty;
  assign push     = wr_vld & (!full | pop);
  assign head_ptr = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign remain   = cnt_q - (AW+1)'(pop);
  assign cnt_d    = remain + (AW+1)'(push);
  assign rd_data  = rd_data_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // rd_data_q always mirrors the entry that will be at the head after this
  // cycle; a push into a queue that drains to nothing bypasses the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= head_ptr;
      cnt_q <= cnt_d;
      if (push && remain == '0)  rd_data_q <= wr_data;
      else if (cnt_d != '0)      rd_data_q <= mem_q[head_ptr];
    end
  end

endmodule

// File: rtl/sa_autosa_sdp_rdma_dat_unpack.sv
// rtl/sa_autosa_sdp_rdma_dat_unpack.sv - slices DMA read beats into framed transfers toward the SDP datapath
module sa_autosa_sdp_rdma_dat_unpack
  import sa_autosa_sdp_rdma_pkg::*;
#(
  parameter int LAT_FIFO_DEPTH = 16
) (
  input  logic                autosa_core_clk,
  input  logic                autosa_core_rstn,
  input  logic                cmd2dat_pvld,
  output logic                cmd2dat_prdy,
  input  logic [CMD_PD_W-1:0] cmd2dat_pd,
  input  logic                dma_rd_rsp_vld,
  output logic                dma_rd_rsp_rdy,
  input  logic [DATA_W-1:0]   dma_rd_rsp_pd,
  output logic                dma_rd_cdt_lat_fifo_pop,
  output logic                sdp_rdma2dp_valid,
  input  logic                sdp_rdma2dp_ready,
  output logic [DP_PD_W-1:0]  sdp_rdma2dp_pd,
  input  logic                op_load,
  output logic                dp2reg_done,
  output logic [STATUS_W-1:0] dp2reg_status_rd_beats
);

  state_e               state_q;
  logic [CMD_CNT_W-1:0] beat_cnt_q;
  logic                 eos_q, lend_q;
  logic                 cdt_pop_q, done_q;
  logic [STATUS_W-1:0]  rd_beats_q, rd_beats_d;
  logic [DATA_W-1:0]    fifo_data;
  logic                 fifo_full, fifo_empty;
  logic                 rsp_push, out_hs, last_beat, cmd_hs;
  logic                 unused_eos;

  sa_autosa_sdp_rdma_lat_fifo #(.DEPTH(LAT_FIFO_DEPTH)) u_lat_fifo (
    .clk     (autosa_core_clk),
    .rst_n   (autosa_core_rstn),
    .wr_vld  (rsp_push),
    .wr_data (dma_rd_rsp_pd),
    .rd_en   (out_hs),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign dma_rd_rsp_rdy    = !fifo_full;
  assign rsp_push          = dma_rd_rsp_vld & dma_rd_rsp_rdy;
  assign last_beat         = (beat_cnt_q == '0);
  assign sdp_rdma2dp_valid = (state_q == ST_ACTIVE) && !fifo_empty;
  assign out_hs            = sdp_rdma2dp_valid & sdp_rdma2dp_ready;
  // Opening the command port on the final handshake lets the next command
  // follow without an idle cycle.
  assign cmd2dat_prdy      = (state_q == ST_IDLE) || (out_hs && last_beat);
  assign cmd_hs            = cmd2dat_pvld & cmd2dat_prdy;
  assign sdp_rdma2dp_pd    = sdp_rdma2dp_valid ? {lend_q & last_beat, last_beat, fifo_data} : '0;

  assign dma_rd_cdt_lat_fifo_pop = cdt_pop_q;
  assign dp2reg_done             = done_q;
  assign dp2reg_status_rd_beats  = rd_beats_q;
  assign unused_eos              = eos_q;

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      eos_q      <= 1'b0;
      lend_q     <= 1'b0;
    end else if (cmd_hs) begin
      state_q    <= ST_ACTIVE;
      beat_cnt_q <= cmd2dat_pd[CMD_CNT_W-1:0];
      eos_q      <= cmd2dat_pd[CMD_EOS_BIT];
      lend_q     <= cmd2dat_pd[CMD_LEND_BIT];
    end else if (out_hs) begin
      if (last_beat) state_q    <= ST_IDLE;
      else           beat_cnt_q <= beat_cnt_q - CMD_CNT_W'(1);
    end
  end

  always_comb begin
    rd_beats_d = rd_beats_q;
    if (op_load)                          rd_beats_d = out_hs ? STATUS_W'(1) : '0;
    else if (out_hs && rd_beats_q != '1)  rd_beats_d = rd_beats_q + STATUS_W'(1);
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      cdt_pop_q  <= 1'b0;
      done_q     <= 1'b0;
      rd_beats_q <= '0;
    end else begin
      cdt_pop_q  <= out_hs;
      done_q     <= out_hs & last_beat & lend_q;
      rd_beats_q <= rd_beats_d;
    end
  end

endmodule

// File: tb/tb_sa_autosa_sdp_rdma_dat_unpack.sv
// tb/tb_sa_autosa_sdp_rdma_dat_unpack.sv - directed self-checking bench for the read-DMA unpack block
module tb_sa_autosa_sdp_rdma_dat_unpack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_pvld = 1'b0;
  logic        cmd_prdy;
  logic [14:0] cmd_pd = '0;
  logic        rsp_vld = 1'b0;
  logic        rsp_rdy;
  logic [63:0] rsp_pd = '0;
  logic        cdt_pop;
  logic        dp_valid;
  logic        dp_ready = 1'b0;
  logic [65:0] dp_pd;
  logic        op_load = 1'b0;
  logic        done;
  logic [31:0] rd_beats;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int credits = 0;
  int dones = 0;
  logic [65:0] out_q[$];
  int          out_cyc[$];
  logic        prev_stall = 1'b0;
  logic        prev_hs = 1'b0;
  logic [65:0] prev_pd = '0;
  bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  sa_autosa_sdp_rdma_dat_unpack #(.LAT_FIFO_DEPTH(16)) dut (
    .autosa_core_clk         (clk),
    .autosa_core_rstn        (rst_n),
    .cmd2dat_pvld            (cmd_pvld),
    .cmd2dat_prdy            (cmd_prdy),
    .cmd2dat_pd              (cmd_pd),
    .dma_rd_rsp_vld          (rsp_vld),
    .dma_rd_rsp_rdy          (rsp_rdy),
    .dma_rd_rsp_pd           (rsp_pd),
    .dma_rd_cdt_lat_fifo_pop (cdt_pop),
    .sdp_rdma2dp_valid       (dp_valid),
    .sdp_rdma2dp_ready       (dp_ready),
    .sdp_rdma2dp_pd          (dp_pd),
    .op_load                 (op_load),
    .dp2reg_done             (done),
    .dp2reg_status_rd_beats  (rd_beats)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("stall_valid", dp_valid, 1);
        check_val("stall_pd", dp_pd, prev_pd);
      end
      check_val("credit_align", cdt_pop, prev_hs);
      if (cdt_pop) credits++;
      if (done) dones++;
      prev_hs = dp_valid & dp_ready;
      prev_stall = dp_valid & !dp_ready;
      prev_pd = dp_pd;
      if (dp_valid & dp_ready) begin
        out_q.push_back(dp_pd);
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    out_q.delete();
    out_cyc.delete();
    credits = 0;
    dones = 0;
  endtask

  task automatic pulse_load();
    op_load = 1'b1;
    tick();
    op_load = 1'b0;
  endtask

  task automatic send_cmd(input int cnt, input bit eos, input bit lend);
    bit ok;
    ok = 1'b0;
    cmd_pvld = 1'b1;
    cmd_pd = {lend, eos, 13'(cnt)};
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (cmd_prdy) ok = 1'b1;
      tick();
    end
    cmd_pvld = 1'b0;
    if (!ok) check_val("cmd_timeout", 0, 1);
  endtask

  task automatic push_beat(input logic [63:0] d);
    bit ok;
    ok = 1'b0;
    rsp_vld = 1'b1;
    rsp_pd = d;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (rsp_rdy) ok = 1'b1;
      tick();
    end
    rsp_vld = 1'b0;
    if (!ok) check_val("push_timeout", 0, 1);
  endtask

  task automatic wait_out(input int n);
    for (int k = 0; k < 500 && out_q.size() < n; k++) tick();
    check_val("out_count", out_q.size(), n);
    repeat (2) tick();
  endtask

  function automatic logic [65:0] got(input int i);
    return (i < out_q.size()) ? out_q[i] : 'x;
  endfunction

  function automatic logic [65:0] ep(input bit lend, input bit last, input logic [63:0] d);
    return {lend, last, d};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", dp_valid, 0);
    check_val("rst_pd", dp_pd, 0);
    check_val("rst_pop", cdt_pop, 0);
    check_val("rst_done", done, 0);
    check_val("rst_status", rd_beats, 0);
    check_val("rst_rsp_rdy", rsp_rdy, 1);
    check_val("rst_prdy", cmd_prdy, 1);
    rst_n = 1'b1;
    tick();

    // single 4-beat layer-end command
    clear_mon();
    dp_ready = 1'b1;
    pulse_load();
    send_cmd(3, 1'b1, 1'b1);
    push_beat(64'h11);
    push_beat(64'h22);
    push_beat(64'h33);
    push_beat(64'h44);
    wait_out(4);
    check_val("single_b0", got(0), ep(0, 0, 64'h11));
    check_val("single_b1", got(1), ep(0, 0, 64'h22));
    check_val("single_b2", got(2), ep(0, 0, 64'h33));
    check_val("single_b3", got(3), ep(1, 1, 64'h44));
    check_val("single_credits", credits, 4);
    check_val("single_done", dones, 1);
    check_val("single_status", rd_beats, 4);

    // back-to-back commands, second offered during the first's final beat
    clear_mon();
    pulse_load();
    send_cmd(0, 1'b0, 1'b0);
    fork
      send_cmd(1, 1'b1, 1'b1);
      begin
        push_beat(64'hA1);
        push_beat(64'hA2);
        push_beat(64'hA3);
      end
    join
    wait_out(3);
    check_val("b2b_b0", got(0), ep(0, 1, 64'hA1));
    check_val("b2b_b1", got(1), ep(0, 0, 64'hA2));
    check_val("b2b_b2", got(2), ep(1, 1, 64'hA3));
    check_val("b2b_no_bubble", (out_cyc.size() == 3) ? out_cyc[2] - out_cyc[0] : -1, 2);
    check_val("b2b_done", dones, 1);
    check_val("b2b_status", rd_beats, 3);

    // ready pattern 1-0-0-1 over an 8-beat command
    clear_mon();
    pulse_load();
    send_cmd(7, 1'b0, 1'b0);
    fork
      for (int i = 0; i < 8; i++) push_beat(64'h100 + 64'(i));
      for (int c = 0; c < 300 && out_q.size() < 8; c++) begin
        dp_ready = pat[c % 4];
        tick();
      end
    join
    dp_ready = 1'b1;
    wait_out(8);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("bp_b%0d", i), got(i), ep(0, i == 7, 64'h100 + 64'(i)));
    check_val("bp_credits", credits, 8);
    check_val("bp_done", dones, 0);
    check_val("bp_status", rd_beats, 8);

    // fill the latency FIFO while the datapath is stalled
    clear_mon();
    pulse_load();
    dp_ready = 1'b0;
    send_cmd(15, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) push_beat(64'h200 + 64'(i));
    check_val("full_rsp_rdy", rsp_rdy, 0);
    check_val("full_no_credit", credits, 0);
    dp_ready = 1'b1;
    wait_out(16);
    for (int i = 0; i < 16; i++)
      check_val($sformatf("full_b%0d", i), got(i), ep(i == 15, i == 15, 64'h200 + 64'(i)));
    check_val("full_credits", credits, 16);
    check_val("full_done", dones, 1);
    check_val("full_rsp_rdy_after", rsp_rdy, 1);

    // reset in the middle of an 8-beat command
    clear_mon();
    send_cmd(7, 1'b1, 1'b1);
    for (int i = 1; i <= 3; i++) push_beat(64'h300 + 64'(i));
    wait_out(3);
    dp_ready = 1'b0;
    for (int i = 4; i <= 8; i++) push_beat(64'h300 + 64'(i));
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", dp_valid, 0);
    check_val("mid_rst_pd", dp_pd, 0);
    check_val("mid_rst_pop", cdt_pop, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_status", rd_beats, 0);
    check_val("mid_rst_rsp_rdy", rsp_rdy, 1);
    check_val("mid_rst_prdy", cmd_prdy, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    clear_mon();
    dp_ready = 1'b1;
    send_cmd(1, 1'b1, 1'b1);
    push_beat(64'h55);
    push_beat(64'h66);
    wait_out(2);
    check_val("post_rst_b0", got(0), ep(0, 0, 64'h55));
    check_val("post_rst_b1", got(1), ep(1, 1, 64'h66));
    check_val("post_rst_status", rd_beats, 2);
    check_val("post_rst_done", dones, 1);

    // op_load coincident with a handshake
    clear_mon();
    dp_ready = 1'b0;
    send_cmd(0, 1'b0, 1'b0);
    push_beat(64'h77);
    dp_ready = 1'b1;
    op_load = 1'b1;
    tick();
    dp_ready = 1'b0;
    op_load = 1'b0;
    repeat (2) tick();
    check_val("load_hs_status", rd_beats, 1);
    check_val("load_hs_b0", got(0), ep(0, 1, 64'h77));
    check_val("load_hs_credits", credits, 1);

    // status counter saturation
    clear_mon();
    force dut.rd_beats_q = 32'hFFFF_FFFE;
    tick();
    release dut.rd_beats_q;
    dp_ready = 1'b1;
    send_cmd(2, 1'b0, 1'b0);
    push_beat(64'h8A);
    push_beat(64'h8B);
    push_beat(64'h8C);
    wait_out(3);
    check_val("sat_status", rd_beats, 32'hFFFF_FFFF);
    check_val("sat_b2", got(2), ep(0, 1, 64'h8C));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_autosa_sdp_rdma_dat_unpack.md
# sa_autosa_sdp_rdma_dat_unpack

Read-side counterpart of the SDP write-DMA data path. It accepts 64-bit DMA read-response beats into a latency FIFO and returns one credit per beat consumed. Per-request commands from the read-command generator slice the beat stream into framed transfers toward the SDP datapath. It reports layer completion and a beat counter to the register file.

## Interface
- LAT_FIFO_DEPTH, 16, latency FIFO entries (power of 2, ≥2); must equal credits granted to the read-request side
- autosa_core_clk  in  1  core clock
- autosa_core_rstn  in  1  reset, asynchronous, active-low
- cmd2dat_pvld  in  1  command valid
- cmd2dat_prdy  out  1  command ready
- cmd2dat_pd  in  15  [12:0] beat count minus 1, [13] end-of-surface, [14] layer end
- dma_rd_rsp_vld  in  1  read-response beat valid
- dma_rd_rsp_rdy  out  1  response ready (latency FIFO not full)
- dma_rd_rsp_pd  in  64  response data
- dma_rd_cdt_lat_fifo_pop  out  1  one-cycle credit return per beat popped
- sdp_rdma2dp_valid  out  1  datapath beat valid
- sdp_rdma2dp_ready  in  1  datapath ready
- sdp_rdma2dp_pd  out  66  [63:0] data, [64] last beat of command, [65] last beat of layer
- op_load  in  1  layer start pulse
- dp2reg_done  out  1  layer-done pulse
- dp2reg_status_rd_beats  out  32  beats delivered this layer

## Operation
- Latency FIFO: write on dma_rd_rsp_vld & dma_rd_rsp_rdy; dma_rd_rsp_rdy = !full. With correct credits the FIFO never fills; a beat offered while full is held, never dropped.
- FSM states:
  - IDLE: cmd2dat_prdy=1. A command handshake loads beat_cnt=pd[12:0], eos=pd[13], lend=pd[14], then moves to ACTIVE.
  - ACTIVE: sdp_rdma2dp_valid = FIFO not empty. Each output handshake pops one entry and decrements beat_cnt.
- Final beat of a command (beat_cnt==0):
  - drives pd[64]=1 and pd[65]=lend.
  - on its handshake: cmd2dat_prdy=1 combinationally in the same cycle.
  - if a new command handshakes in that cycle, stay in ACTIVE with the new fields loaded; otherwise return to IDLE.
- eos is carried only for the command-to-command sequence check; it does not alter data.
- Command counts are 13-bit, 1 to 8192 beats. beat_cnt never underflows.
- Status counter:
  - op_load clears dp2reg_status_rd_beats to 0; +1 per output handshake; saturates at 0xFFFFFFFF.
  - If op_load and a handshake coincide, the count becomes 1.
  - op_load does not affect the FSM or the FIFO.
- Reset mid-operation: FIFO emptied, FSM to IDLE, counters cleared. Outstanding DMA responses are the upstream's responsibility.

## Timing
- Reset values:
  - sdp_rdma2dp_valid=0, sdp_rdma2dp_pd=0
  - dma_rd_cdt_lat_fifo_pop=0, dp2reg_done=0, dp2reg_status_rd_beats=0
  - dma_rd_rsp_rdy=1, cmd2dat_prdy=1
- Latency:
  - A response beat accepted in cycle N is visible on sdp_rdma2dp_valid in N+1 when the FIFO was empty and a command is ACTIVE.
  - If the command arrives later, the beat appears in the cycle after the command handshake.
- Output handshake rules:
  - sdp_rdma2dp_valid/pd hold stable while ready=0.
  - Valid never drops without a handshake.
  - Valid is never asserted in IDLE.
- Credit return: dma_rd_cdt_lat_fifo_pop is registered and pulses in the cycle after each output handshake. Back-to-back handshakes give back-to-back pulses.
- dp2reg_done is registered and pulses for one cycle after the handshake of a beat with pd[65]=1.
- FIFO pop and push in the same cycle while full is legal; occupancy stays unchanged.

## Structure
- Shared package sa_autosa_sdp_rdma_pkg: command field offsets, 64-bit data width, 66-bit output pd layout, FSM state enum.
- Sub-module sa_autosa_sdp_rdma_lat_fifo: synchronous FIFO, LAT_FIFO_DEPTH × 64, registered read data, full/empty outputs.
- Top: command FSM, beat counter, credit/done registers, status counter.

## Test plan
- Single command: cmd pd[12:0]=3, lend=1; 4 beats 0x11..0x44. Expect 4 outputs in order, last flags only on 0x44, 4 credit pulses, one dp2reg_done, status=4.
- Back-to-back commands 0 and 1, lend=0 then 1; second command offered during final beat. Expect no IDLE bubble, 3 beats out, pd[64] on beats 1 and 3, done once.
- Backpressure: ready toggling 1-0-0-1 on an 8-beat command. Expect pd stable while stalled, credits exactly 8, none during stalls.
- FIFO full: 16 beats pushed with ready=0. Expect dma_rd_rsp_rdy=0 at 16 entries, no loss, all 16 drained in order after ready=1.
- Reset asserted mid-command (3 of 8 beats delivered). Expect all outputs at reset values immediately. A fresh 2-beat command then completes normally with status=2.
- op_load coincident with a handshake. Expect status=1. Saturation pre-load near the limit holds at 0xFFFFFFFF.
